// File: rtl/uart_echo_ctrl_if.sv
// Parallel-side handshake bundle between the echo controller and CoreUART.
// The controller owns the master modport; CoreUART (or its VIP) owns the slave modport.
interface uart_echo_ctrl_if;
  logic       uart_rxrdy;
  logic [7:0] uart_data_out;
  logic       uart_oen;
  logic       uart_txrdy;
  logic       uart_wen;
  logic [7:0] uart_data_in;

  modport master (
    input  uart_rxrdy, uart_data_out, uart_txrdy,
    output uart_oen, uart_wen, uart_data_in
  );

  modport slave (
    output uart_rxrdy, uart_data_out, uart_txrdy,
    input  uart_oen, uart_wen, uart_data_in
  );
endinterface

// File: rtl/uart_echo_ctrl.sv
// CoreUART echo controller: reads each received byte into a small FIFO and
// writes it back out through the transmitter, preserving order.
module uart_echo_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 2,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_echo_ctrl_if.master              uart,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rx_stall,
  output logic [CNT_W-1:0]              echo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {RX_IDLE, RX_READ, RX_WAIT} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_HOLD, TX_WAIT} tx_state_e;

  rx_state_e        rx_state_q;
  tx_state_e        tx_state_q;
  logic             oen_q;
  logic             wen_q;
  logic [7:0]       data_in_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [3:0]       hold_q;
  logic [CNT_W-1:0] count_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  // The push lands on the edge that ends the oen-low cycle.
  assign push       = (rx_state_q == RX_READ);
  assign pop        = (tx_state_q == TX_IDLE) && !fifo_empty && uart.uart_txrdy;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      oen_q      <= 1'b1;
    end else begin
      case (rx_state_q)
        RX_IDLE: if (uart.uart_rxrdy && !fifo_full) begin
          oen_q      <= 1'b0;
          rx_state_q <= RX_READ;
        end
        RX_READ: begin
          oen_q      <= 1'b1;
          rx_state_q <= RX_WAIT;
        end
        RX_WAIT: if (!uart.uart_rxrdy) rx_state_q <= RX_IDLE;
        default: begin
          oen_q      <= 1'b1;
          rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  // NOTE: the byte storage has no reset; emptiness is tracked by the pointers
  // and level alone, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= uart.uart_data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      wen_q      <= 1'b1;
      data_in_q  <= 8'h00;
      hold_q     <= '0;
      count_q    <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (pop) begin
          data_in_q  <= mem_q[rd_ptr_q];
          wen_q      <= 1'b0;
          tx_state_q <= TX_STROBE;
        end
        TX_STROBE: begin
          wen_q      <= 1'b1;
          count_q    <= count_q + CNT_W'(1);
          hold_q     <= 4'(HOLDOFF);
          tx_state_q <= TX_HOLD;
        end
        // txrdy may still read stale-high right after a write; ignore it here.
        TX_HOLD: begin
          hold_q <= hold_q - 4'd1;
          if (hold_q == 4'd1) tx_state_q <= TX_WAIT;
        end
        TX_WAIT: if (uart.uart_txrdy) tx_state_q <= TX_IDLE;
        default: begin
          wen_q      <= 1'b1;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign uart.uart_oen     = oen_q;
  assign uart.uart_wen     = wen_q;
  assign uart.uart_data_in = data_in_q;
  assign fifo_level        = level_q;
  assign echo_count        = count_q;
  assign rx_stall          = uart.uart_rxrdy && fifo_full;
endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench for uart_echo_ctrl: CoreUART-like stubs on both sides,
// a queue-based reference model checked every cycle, and directed scenarios.
module tb_uart_echo_ctrl;
  localparam int FIFO_DEPTH = 4;
  localparam int HOLDOFF    = 2;
  localparam int CNT_W      = 16;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_echo_ctrl_if uart();
  logic [LW-1:0]    fifo_level;
  logic             rx_stall;
  logic [CNT_W-1:0] echo_count;

  uart_echo_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart       (uart),
    .fifo_level (fifo_level),
    .rx_stall   (rx_stall),
    .echo_count (echo_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus-side stubs
  logic       rx_rdy_r = 1'b0;
  logic [7:0] rx_data_r = 8'h00;
  logic       tx_force = 1'b0;
  logic       vip_mode = 1'b0;
  logic       vip_rdy = 1'b1;
  logic       rx_sticky = 1'b0;
  byte unsigned rx_q[$];
  bit         rx_pending = 1'b0;
  int         vip_busy = 0;

  assign uart.uart_rxrdy    = rx_rdy_r;
  assign uart.uart_data_out = rx_data_r;
  assign uart.uart_txrdy    = vip_mode ? vip_rdy : tx_force;

  // Receiver stub: presents queued bytes, drops rxrdy after each read unless sticky.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_q.delete();
      rx_pending = 1'b0;
      rx_rdy_r   = 1'b0;
    end else if (!uart.uart_oen) begin
      rx_pending = 1'b1;
    end else if (rx_pending) begin
      rx_pending = 1'b0;
      void'(rx_q.pop_front());
      if (!rx_sticky) rx_rdy_r = 1'b0;
    end else if (!rx_rdy_r && rx_q.size() > 0) begin
      rx_rdy_r  = 1'b1;
      rx_data_r = rx_q[0];
    end else if (!rx_sticky && rx_rdy_r && rx_q.size() == 0) begin
      rx_rdy_r = 1'b0;
    end
  end

  // Transmitter stub: txrdy goes low for 11 cycles after each write strobe.
  always @(negedge clk) begin
    if (!uart.uart_wen) begin
      vip_busy = 11;
      vip_rdy  = 1'b0;
    end else if (vip_busy > 0) begin
      vip_busy--;
      if (vip_busy == 0) vip_rdy = 1'b1;
    end
  end

  // Reference model and per-cycle compare
  byte unsigned exp_q[$];
  byte unsigned out_log[$];
  int           wen_times[$];
  int           level_m = 0;
  int           count_m = 0;
  int           oen_pulses = 0;
  int           gap = 100;
  int           cyc = 0;
  bit           prev_oen_low = 1'b0;
  bit           prev_wen_low = 1'b0;
  bit           need_low = 1'b0;
  byte unsigned pend_byte = 8'h00;

  always @(posedge clk) begin
    int  level_before;
    bit  rx_idle;
    bit  oen_low;
    bit  wen_low;
    byte unsigned b;
    #1;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      level_m      = 0;
      count_m      = 0;
      gap          = 100;
      prev_oen_low = 1'b0;
      prev_wen_low = 1'b0;
      need_low     = 1'b0;
    end else begin
      level_before = level_m;
      rx_idle      = !prev_oen_low && !need_low;
      oen_low      = !uart.uart_oen;
      wen_low      = !uart.uart_wen;

      // A read starts only on a fresh rxrdy with room in the buffer, and lasts one cycle.
      check("oen_rule", oen_low, rx_idle && uart.uart_rxrdy && (level_before < FIFO_DEPTH));
      if (prev_oen_low) need_low = 1'b1;
      else if (need_low && !uart.uart_rxrdy) need_low = 1'b0;

      gap++;
      if (wen_low) begin
        check("wen_width", prev_wen_low, 1'b0);
        check("wen_txrdy", uart.uart_txrdy, 1'b1);
        check("wen_gap", gap >= HOLDOFF + 3, 1'b1);
        check("pop_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          check("data_in_order", uart.uart_data_in, b);
        end
        out_log.push_back(uart.uart_data_in);
        wen_times.push_back(cyc);
        level_m--;
        gap = 0;
      end
      if (prev_oen_low) begin
        exp_q.push_back(pend_byte);
        level_m++;
      end
      if (prev_wen_low) count_m++;
      if (oen_low) begin
        pend_byte = uart.uart_data_out;
        oen_pulses++;
      end

      check("fifo_level", fifo_level, level_m);
      check("echo_count", echo_count, CNT_W'(count_m));
      check("rx_stall", rx_stall, uart.uart_rxrdy && (level_m == FIFO_DEPTH));
      prev_oen_low = oen_low;
      prev_wen_low = wen_low;
    end
  end

  task automatic wait_count(input int target, input int budget, input string name);
    int i = 0;
    while (echo_count != CNT_W'(target) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, echo_count, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int first;
    int i;
    repeat (3) @(negedge clk);
    check("rst_oen", uart.uart_oen, 1'b1);
    check("rst_wen", uart.uart_wen, 1'b1);
    check("rst_data_in", uart.uart_data_in, 8'h00);
    check("rst_level", fifo_level, 0);
    check("rst_count", echo_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte echo
    tx_force = 1'b1;
    base = oen_pulses;
    rx_q.push_back(8'hA5);
    wait_count(1, 100, "single_count");
    repeat (10) @(negedge clk);
    check("single_data", uart.uart_data_in, 8'hA5);
    check("single_log", out_log[0], 8'hA5);
    check("single_level", fifo_level, 0);
    check("single_reads", oen_pulses - base, 1);

    // Burst with transmitter blocked: fills to depth, fifth byte stalls
    tx_force = 1'b0;
    repeat (2) @(negedge clk);
    base = oen_pulses;
    for (int k = 1; k <= 5; k++) rx_q.push_back(byte'(k));
    repeat (40) @(negedge clk);
    check("burst_level", fifo_level, 4);
    check("burst_stall", rx_stall, 1'b1);
    check("burst_reads", oen_pulses - base, 4);
    check("burst_count_held", echo_count, 1);
    tx_force = 1'b1;
    wait_count(6, 200, "burst_count");
    repeat (15) @(negedge clk);
    for (int k = 1; k <= 5; k++) check("burst_order", out_log[k], k);
    check("burst_reads_all", oen_pulses - base, 5);

    // Transmitter stub with 11-cycle busy window after each write
    vip_mode = 1'b1;
    first = wen_times.size();
    for (int k = 0; k < 8; k++) rx_q.push_back(byte'(8'h80 + k));
    wait_count(14, 600, "vip_count");
    repeat (5) @(negedge clk);
    for (int k = first + 1; k < first + 8; k++)
      check("vip_gap_ge13", (wen_times[k] - wen_times[k-1]) >= 13, 1'b1);
    for (int k = 0; k < 8; k++) check("vip_order", out_log[6 + k], 8'h80 + k);

    // Push and pop on the same edge at level 2
    vip_mode = 1'b0;
    tx_force = 1'b1;
    repeat (15) @(negedge clk);
    tx_force = 1'b0;
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h22);
    repeat (30) @(negedge clk);
    check("conc_pre_level", fifo_level, 2);
    rx_q.push_back(8'h33);
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (uart.uart_oen && i < 50);
    check("conc_oen_seen", uart.uart_oen, 1'b0);
    tx_force = 1'b1;
    @(posedge clk);
    #1;
    check("conc_level", fifo_level, 2);
    check("conc_wen", uart.uart_wen, 1'b0);
    check("conc_head", uart.uart_data_in, 8'h11);
    wait_count(17, 200, "conc_count");
    check("conc_order0", out_log[14], 8'h11);
    check("conc_order1", out_log[15], 8'h22);
    check("conc_order2", out_log[16], 8'h33);

    // rxrdy held high long after one read
    repeat (5) @(negedge clk);
    base = oen_pulses;
    rx_sticky = 1'b1;
    rx_q.push_back(8'h44);
    repeat (25) @(negedge clk);
    check("sticky_reads", oen_pulses - base, 1);
    rx_sticky = 1'b0;
    wait_count(18, 100, "sticky_count");
    check("sticky_data", out_log[17], 8'h44);

    // Reset while a write strobe is low
    tx_force = 1'b0;
    repeat (5) @(negedge clk);
    rx_q.push_back(8'h55);
    rx_q.push_back(8'h66);
    rx_q.push_back(8'h77);
    repeat (30) @(negedge clk);
    check("rstmid_pre_level", fifo_level, 3);
    tx_force = 1'b1;
    i = 0;
    do begin
      @(posedge clk);
      #1;
      i++;
    end while (uart.uart_wen && i < 20);
    check("rstmid_wen_low", uart.uart_wen, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_wen", uart.uart_wen, 1'b1);
    check("rstmid_oen", uart.uart_oen, 1'b1);
    check("rstmid_level", fifo_level, 0);
    check("rstmid_count", echo_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_data_in", uart.uart_data_in, 8'h00);
    @(negedge clk);
    rx_q.push_back(8'h3C);
    wait_count(1, 100, "post_rst_count");
    repeat (10) @(negedge clk);
    check("post_rst_data", uart.uart_data_in, 8'h3C);
    check("post_rst_log", out_log[out_log.size() - 1], 8'h3C);
    check("post_rst_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_echo_ctrl.md
Name: uart_echo_ctrl

Overview:
Host-side controller for the CoreUART parallel interface. It is the bus-master end of the rxrdy/oen/data_out and txrdy/wen/data_in handshakes. It reads every received byte from CoreUART into a small FIFO and writes each byte back out through the CoreUART transmitter in order. It sits between CoreUART (or coreuart_vip in simulation) and the status logic of the echo design.

Parameters:
FIFO_DEPTH, 4, echo buffer depth in bytes; power of two, minimum 2
HOLDOFF, 2, cycles after a wen strobe during which uart_txrdy is ignored; range 1..15
CNT_W, 16, width of echo_count

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
uart_rxrdy  input  1  CoreUART received byte available
uart_data_out  input  8  CoreUART received byte
uart_oen  output  1  CoreUART read strobe, active-low
uart_txrdy  input  1  CoreUART transmitter can accept a byte
uart_wen  output  1  CoreUART write strobe, active-low
uart_data_in  output  8  byte to CoreUART transmitter
fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered
rx_stall  output  1  uart_rxrdy high while FIFO full (combinational)
echo_count  output  CNT_W  bytes written to CoreUART; wraps to 0

Behaviour:
- Reset (async, rst_n=0): uart_oen=1, uart_wen=1, uart_data_in=8'h00, FIFO emptied, fifo_level=0, echo_count=0, both FSMs idle. Reset mid-strobe forces the strobe high immediately. The byte in flight is discarded.
- All outputs except rx_stall are registered. Strobes are exactly one clk cycle low.
- RX FSM (RX_IDLE, RX_READ, RX_WAIT):
  - RX_IDLE: if uart_rxrdy=1 and FIFO not full, assert uart_oen=0 at the next edge and go to RX_READ. Otherwise stay.
  - RX_READ (oen low): at the next edge, push uart_data_out into the FIFO, set uart_oen=1, go to RX_WAIT.
  - RX_WAIT: stay until uart_rxrdy=0, then go to RX_IDLE. This guarantees one read per byte.
  - FIFO full with rxrdy=1: no read is issued and rx_stall=1. The block never drops data; overrun is CoreUART's concern.
- TX FSM (TX_IDLE, TX_STROBE, TX_HOLD, TX_WAIT):
  - TX_IDLE: if FIFO not empty and uart_txrdy=1, at the next edge load uart_data_in with the FIFO head, pop, set uart_wen=0, go to TX_STROBE.
  - TX_STROBE: at the next edge set uart_wen=1, increment echo_count (modulo 2^CNT_W), load the holdoff counter with HOLDOFF, go to TX_HOLD.
  - TX_HOLD: decrement the counter each cycle, ignoring uart_txrdy. At 0, go to TX_WAIT.
  - TX_WAIT: go to TX_IDLE when uart_txrdy=1.
  - uart_data_in holds its value until the next load.
- Latency: rxrdy rising while idle and empty to wen falling is 3 edges minimum (oen low, push, wen low), provided txrdy=1.
- FIFO: circular buffer with wrap-around pointers.
  - Push and pop in the same cycle are both honoured; fifo_level is unchanged.
  - Pop on empty and push on full cannot occur by construction. The bench asserts this.
  - Byte order is strictly preserved.
- The RX and TX FSMs run concurrently and independently. Only the FIFO couples them.

Test Plan:
- Single byte: rxrdy=1, data_out=8'hA5 -> one oen low pulse, uart_data_in=8'hA5 with one wen low pulse, echo_count=1, fifo_level returns to 0.
- Burst with txrdy held 0: bytes 8'h01..8'h05 -> 4 reads, fifo_level=4, rx_stall=1 on the 5th byte with no oen pulse. On txrdy=1, output order is 01,02,03,04 and then 05 is read and echoed.
- coreuart_vip transmit stub (txrdy low 11 cycles after each wen): 8 queued bytes -> each wen is issued only after txrdy returns high, wen pulses are ≥13 cycles apart, and no byte is lost.
- Concurrent push/pop: read completes on the same edge as a TX pop with level=2 -> level stays 2 and the data order is intact.
- rxrdy held high for 20 cycles after one read -> exactly one oen pulse (RX_WAIT guard).
- Reset asserted while uart_wen=0 -> uart_wen=1 and uart_oen=1 immediately (asynchronous), fifo_level=0, echo_count=0. After release, the next byte 8'h3C echoes normally.
